rb_wr_arb: RTL and testbench

Write-side arbiter and credit controller for the multi-port ring buffer. It shares the buffer's `WRITE` write lanes among `REQ` independent requesters, granting up to `WRITE` requests per cycle in round-robin order. Grants are limited by a free-entry credit counter, and granted data is packed onto contiguous lanes starting at lane 0. The block also sequences buffer flushes, so the buffer's `busy` output is never relied upon for overflow protection.

---
 rtl/rb_wr_arb_if.sv | 32 +++
 rtl/rb_wr_arb.sv | 117 +++++++++++
 tb/tb_rb_wr_arb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rb_wr_arb_if.sv
// Bundle between requesters, the ring-buffer consumer and the write arbiter.
// The arbiter connects through slave; the requester/consumer side connects through master.
interface rb_wr_arb_if #(
  parameter int REQ   = 4,
  parameter int WRITE = 4,
  parameter int READ  = 4,
  parameter int DATA  = 64,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [REQ-1:0]              req;
  logic [REQ-1:0][DATA-1:0]    req_data;
  logic [REQ-1:0]              gnt;
  logic [READ-1:0]             pop;
  logic                        flush_req;
  logic [WRITE-1:0]            wb_we;
  logic [WRITE-1:0][DATA-1:0]  wb_wd;
  logic                        wb_flush_;
  logic [CW-1:0]               credit;
  logic                        full;

  modport master (
    output req, req_data, pop, flush_req,
    input  gnt, wb_we, wb_wd, wb_flush_, credit, full
  );

  modport slave (
    input  req, req_data, pop, flush_req,
    output gnt, wb_we, wb_wd, wb_flush_, credit, full
  );
endinterface

// File: rtl/rb_wr_arb.sv
// Round-robin write arbiter with credit control and flush sequencing for the ring buffer.
// gnt is same-cycle combinational; lane writes register 1 cycle later; no credit means no grant.
module rb_wr_arb #(
  parameter int REQ   = 4,
  parameter int WRITE = 4,
  parameter int READ  = 4,
  parameter int DATA  = 64,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  rb_wr_arb_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (REQ > 1) ? $clog2(REQ) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                     state, state_n;
  logic [CW-1:0]              credit_q, credit_n;
  logic [RW-1:0]              rr_q, rr_n;
  logic [WRITE-1:0]           we_q, we_n;
  logic [WRITE-1:0][DATA-1:0] wd_q, wd_n;
  logic                       flush_q, flush_n;
  logic [REQ-1:0]             gnt_c;
  logic                       scan_en;
  int                         ngnt;
  int                         last_gnt;

  // Gating on reset keeps gnt low for the whole time reset is held.
  assign scan_en = reset && (state == ST_RUN) && !bus.flush_req;

  always_comb begin : scan
    int limit;
    int idx;
    gnt_c    = '0;
    we_n     = '0;
    wd_n     = '0;
    ngnt     = 0;
    last_gnt = 0;
    idx      = 0;
    limit    = (int'(credit_q) < WRITE) ? int'(credit_q) : WRITE;
    if (scan_en) begin
      for (int i = 0; i < REQ; i++) begin
        idx = int'(rr_q) + i;
        if (idx >= REQ) idx = idx - REQ;
        for (int j = 0; j < REQ; j++) begin
          if (j == idx && bus.req[j] && ngnt < limit) begin
            gnt_c[j] = 1'b1;
            // The k-th grant in scan order lands on lane k.
            for (int k = 0; k < WRITE; k++) begin
              if (k == ngnt) begin
                we_n[k] = 1'b1;
                wd_n[k] = bus.req_data[j];
              end
            end
            ngnt     = ngnt + 1;
            last_gnt = j;
          end
        end
      end
    end
  end

  always_comb begin : next_state
    int c;
    state_n  = state;
    credit_n = credit_q;
    rr_n     = rr_q;
    flush_n  = 1'b1;
    c = int'(credit_q) - ngnt + int'($countones(bus.pop));
    if (c > DEPTH) c = DEPTH;
    if (c < 0)     c = 0;
    case (state)
      ST_RUN: begin
        credit_n = CW'(c);
        if (bus.flush_req) begin
          state_n = ST_FLUSH;
          flush_n = 1'b0;
        end else if (ngnt > 0) begin
          rr_n = RW'((last_gnt + 1) % REQ);
        end
      end
      ST_FLUSH: begin
        state_n  = ST_RUN;
        credit_n = CW'(DEPTH);
        rr_n     = '0;
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      credit_q <= CW'(DEPTH);
      rr_q     <= '0;
      we_q     <= '0;
      wd_q     <= '0;
      flush_q  <= 1'b1;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      rr_q     <= rr_n;
      we_q     <= we_n;
      wd_q     <= wd_n;
      flush_q  <= flush_n;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.wb_we     = we_q;
  assign bus.wb_wd     = wd_q;
  assign bus.wb_flush_ = flush_q;
  assign bus.credit    = credit_q;
  assign bus.full      = (credit_q == '0);
endmodule

// File: tb/tb_rb_wr_arb.sv
// Bench for rb_wr_arb: directed scenarios plus random traffic against a queue-free scan model.
// A second instance with a single write lane covers round-robin fairness.
module tb_rb_wr_arb;
  localparam int REQ   = 4;
  localparam int WRITE = 4;
  localparam int READ  = 4;
  localparam int DATA  = 64;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rb_wr_arb_if #(.REQ(REQ), .WRITE(WRITE), .READ(READ), .DATA(DATA), .DEPTH(DEPTH)) ifa();
  rb_wr_arb_if #(.REQ(REQ), .WRITE(1),     .READ(READ), .DATA(DATA), .DEPTH(DEPTH)) ifb();

  rb_wr_arb #(.REQ(REQ), .WRITE(WRITE), .READ(READ), .DATA(DATA), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  rb_wr_arb #(.REQ(REQ), .WRITE(1), .READ(READ), .DATA(DATA), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state for dut_a
  int                  m_credit;
  int                  m_rr;
  bit                  m_inflush;
  logic [3:0]          m_we;
  logic [3:0][63:0]    m_wd;
  logic                m_fl;
  logic [3:0]          obs_gnt;

  function automatic logic [63:0] dat(input logic [7:0] tag, input int i);
    return {tag, 48'h5A5A_0000_0000, 8'(i)};
  endfunction

  task automatic model_reset();
    m_credit = DEPTH; m_rr = 0; m_inflush = 0; m_we = '0; m_wd = '0; m_fl = 1'b1;
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic f);
    logic [3:0] g;
    int lim, n, idx;
    g = '0;
    if (m_inflush || f) return g;
    lim = (m_credit < WRITE) ? m_credit : WRITE;
    n = 0;
    for (int i = 0; i < REQ; i++) begin
      idx = (m_rr + i) % REQ;
      if (r[idx] && n < lim) begin g[idx] = 1'b1; n++; end
    end
    return g;
  endfunction

  task automatic model_clock(input logic [3:0] r, input logic [3:0][63:0] d,
                             input logic [3:0] p, input logic f);
    logic [3:0] g;
    int n, idx, last;
    if (m_inflush) begin
      m_we = '0; m_wd = '0; m_fl = 1'b1; m_credit = DEPTH; m_rr = 0; m_inflush = 0;
    end else if (f) begin
      m_we = '0; m_wd = '0; m_fl = 1'b0; m_inflush = 1;
      m_credit = m_credit + $countones(p);
    end else begin
      g = model_gnt(r, 1'b0);
      m_we = '0; m_wd = '0; m_fl = 1'b1; n = 0; last = -1;
      for (int i = 0; i < REQ; i++) begin
        idx = (m_rr + i) % REQ;
        if (g[idx]) begin m_we[n] = 1'b1; m_wd[n] = d[idx]; n++; last = idx; end
      end
      m_credit = m_credit - n + $countones(p);
      if (last >= 0) m_rr = (last + 1) % REQ;
    end
    assert (m_credit >= 0 && m_credit <= DEPTH) else $error("consumer popped more than outstanding");
  endtask

  // One clock of dut_a with the currently driven inputs, checked against the model.
  task automatic tick(input string nm);
    logic [3:0] eg, r, p;
    logic [3:0][63:0] d;
    logic f;
    r = ifa.req; d = ifa.req_data; p = ifa.pop; f = ifa.flush_req;
    eg = model_gnt(r, f);
    #1;
    n_tests++;
    if (ifa.gnt !== eg) begin n_fail++; $display("FAIL %s gnt got %b want %b", nm, ifa.gnt, eg); end
    obs_gnt = ifa.gnt;
    @(posedge clk);
    model_clock(r, d, p, f);
    #1;
    n_tests++;
    if (ifa.wb_we !== m_we) begin n_fail++; $display("FAIL %s wb_we got %b want %b", nm, ifa.wb_we, m_we); end
    n_tests++;
    if (ifa.wb_wd !== m_wd) begin n_fail++; $display("FAIL %s wb_wd got %h want %h", nm, ifa.wb_wd, m_wd); end
    n_tests++;
    if (ifa.wb_flush_ !== m_fl) begin n_fail++; $display("FAIL %s wb_flush_ got %b want %b", nm, ifa.wb_flush_, m_fl); end
    n_tests++;
    if (ifa.credit !== 5'(m_credit)) begin n_fail++; $display("FAIL %s credit got %0d want %0d", nm, ifa.credit, m_credit); end
    n_tests++;
    if (ifa.full !== (m_credit == 0)) begin n_fail++; $display("FAIL %s full got %b want %b", nm, ifa.full, m_credit == 0); end
    @(negedge clk);
  endtask

  task automatic set_data(input logic [7:0] tag);
    for (int i = 0; i < REQ; i++) ifa.req_data[i] = dat(tag, i);
  endtask

  task automatic do_reset();
    reset = 1'b0; #2; reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    ifa.req = 4'b1111; set_data(8'h11);
    #1;
    n_tests++; if (ifa.gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_init gnt got %b want 0000", ifa.gnt); end
    n_tests++; if (ifa.credit !== 5'd16) begin n_fail++; $display("FAIL rst_init credit got %0d want 16", ifa.credit); end
    @(negedge clk); reset = 1'b1; model_reset();
    ifa.req = 4'b0001; tick("rst_pre0");
    ifa.req = 4'b1111; tick("rst_pre1");
    reset = 1'b0;
    #1;
    n_tests++; if (ifa.gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_mid gnt got %b want 0000", ifa.gnt); end
    n_tests++; if (ifa.wb_we !== 4'b0000) begin n_fail++; $display("FAIL rst_mid wb_we got %b want 0000", ifa.wb_we); end
    n_tests++; if (ifa.wb_flush_ !== 1'b1) begin n_fail++; $display("FAIL rst_mid wb_flush_ got %b want 1", ifa.wb_flush_); end
    n_tests++; if (ifa.credit !== 5'd16) begin n_fail++; $display("FAIL rst_mid credit got %0d want 16", ifa.credit); end
    n_tests++; if (ifa.full !== 1'b0) begin n_fail++; $display("FAIL rst_mid full got %b want 0", ifa.full); end
    model_reset();
    @(negedge clk); reset = 1'b1;
    tick("rst_post");
    n_tests++;
    if (ifa.wb_wd[0] !== dat(8'h11, 0)) begin n_fail++; $display("FAIL rst_order lane0 got %h want %h", ifa.wb_wd[0], dat(8'h11, 0)); end
  endtask

  task automatic test_fill();
    logic [3:0] g_exp;
    do_reset();
    ifa.req = 4'b1111; ifa.pop = '0; set_data(8'h22);
    for (int k = 0; k < 5; k++) begin
      tick("fill");
      g_exp = (k < 4) ? 4'b1111 : 4'b0000;
      n_tests++; if (obs_gnt !== g_exp) begin n_fail++; $display("FAIL fill gnt[%0d] got %b want %b", k, obs_gnt, g_exp); end
      n_tests++; if (ifa.credit !== 5'((k < 4) ? 12 - 4 * k : 0)) begin n_fail++; $display("FAIL fill credit[%0d] got %0d", k, ifa.credit); end
      n_tests++; if (ifa.wb_we !== ((k < 4) ? 4'b1111 : 4'b0000)) begin n_fail++; $display("FAIL fill wb_we[%0d] got %b", k, ifa.wb_we); end
      n_tests++; if (ifa.full !== (k >= 3)) begin n_fail++; $display("FAIL fill full[%0d] got %b want %b", k, ifa.full, k >= 3); end
    end
  endtask

  task automatic test_pack();
    do_reset();
    ifa.pop = '0; set_data(8'h33);
    ifa.req = 4'b0001; tick("pack_prep");
    ifa.req = 4'b1111; tick("pack_prep"); tick("pack_prep"); tick("pack_prep");
    ifa.req = 4'b0001; tick("pack_prep");
    set_data(8'hC0);
    ifa.req = 4'b1111; tick("pack");
    n_tests++; if (obs_gnt !== 4'b0110) begin n_fail++; $display("FAIL pack gnt got %b want 0110", obs_gnt); end
    n_tests++; if (ifa.wb_we !== 4'b0011) begin n_fail++; $display("FAIL pack wb_we got %b want 0011", ifa.wb_we); end
    n_tests++; if (ifa.wb_wd[0] !== dat(8'hC0, 1)) begin n_fail++; $display("FAIL pack lane0 got %h", ifa.wb_wd[0]); end
    n_tests++; if (ifa.wb_wd[1] !== dat(8'hC0, 2)) begin n_fail++; $display("FAIL pack lane1 got %h", ifa.wb_wd[1]); end
    n_tests++; if (ifa.credit !== 5'd0) begin n_fail++; $display("FAIL pack credit got %0d want 0", ifa.credit); end
    ifa.pop = 4'b0011; tick("pack_pop");
    ifa.pop = '0; tick("pack_rr");
    n_tests++; if (obs_gnt !== 4'b1001) begin n_fail++; $display("FAIL pack_rr gnt got %b want 1001", obs_gnt); end
  endtask

  task automatic test_pop_req();
    ifa.pop = 4'b0011; ifa.req = 4'b0001; tick("popreq0");
    n_tests++; if (obs_gnt !== 4'b0000) begin n_fail++; $display("FAIL popreq gnt0 got %b want 0000", obs_gnt); end
    n_tests++; if (ifa.credit !== 5'd2) begin n_fail++; $display("FAIL popreq credit got %0d want 2", ifa.credit); end
    ifa.pop = '0; tick("popreq1");
    n_tests++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL popreq gnt1 got %b want 0001", obs_gnt); end
  endtask

  task automatic test_flush();
    do_reset();
    ifa.req = 4'b1111; ifa.pop = '0; ifa.flush_req = 1'b0; set_data(8'h44);
    tick("flush_pre");
    n_tests++; if (ifa.wb_we !== 4'b1111) begin n_fail++; $display("FAIL flush wb_we_t got %b want 1111", ifa.wb_we); end
    ifa.flush_req = 1'b1; tick("flush_t");
    n_tests++; if (obs_gnt !== 4'b0000) begin n_fail++; $display("FAIL flush gnt_t got %b want 0000", obs_gnt); end
    n_tests++; if (ifa.wb_flush_ !== 1'b0) begin n_fail++; $display("FAIL flush wb_flush_ got %b want 0", ifa.wb_flush_); end
    ifa.pop = 4'b1111; tick("flush_t1");
    n_tests++; if (obs_gnt !== 4'b0000) begin n_fail++; $display("FAIL flush gnt_t1 got %b want 0000", obs_gnt); end
    n_tests++; if (ifa.credit !== 5'd16) begin n_fail++; $display("FAIL flush credit got %0d want 16", ifa.credit); end
    ifa.flush_req = 1'b0; ifa.pop = '0; tick("flush_t2");
    n_tests++; if (obs_gnt !== 4'b1111) begin n_fail++; $display("FAIL flush gnt_t2 got %b want 1111", obs_gnt); end
    n_tests++; if (ifa.wb_wd[0] !== dat(8'h44, 0)) begin n_fail++; $display("FAIL flush rr lane0 got %h", ifa.wb_wd[0]); end
  endtask

  task automatic test_random();
    logic [3:0] p;
    int cap;
    do_reset();
    ifa.req = '0; ifa.pop = '0; ifa.flush_req = 1'b0;
    obs_gnt = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < REQ; i++) begin
        if (!ifa.req[i] || obs_gnt[i]) begin
          ifa.req[i] = ($urandom_range(0, 2) != 0);
          ifa.req_data[i] = {$urandom, $urandom};
        end else if ($urandom_range(0, 15) == 0) begin
          ifa.req[i] = 1'b0;
        end
      end
      cap = DEPTH - m_credit;
      p = 4'($urandom);
      while ($countones(p) > cap) p = p & (p - 4'd1);
      ifa.pop = p;
      ifa.flush_req = ($urandom_range(0, 39) == 0);
      tick("random");
    end
    ifa.req = '0; ifa.pop = '0; ifa.flush_req = 1'b0;
  endtask

  task automatic test_round_robin();
    int wait_cnt [4];
    int max_wait, exp_cr, gi;
    logic [3:0] g_exp;
    do_reset();
    for (int i = 0; i < REQ; i++) begin ifb.req_data[i] = dat(8'hB0, i); wait_cnt[i] = 0; end
    ifb.req = 4'b1001;
    max_wait = 0; exp_cr = DEPTH;
    for (int c = 0; c < 8; c++) begin
      ifb.pop = (c >= 2) ? 4'b0001 : 4'b0000;
      gi = (c % 2 == 0) ? 0 : 3;
      g_exp = (c % 2 == 0) ? 4'b0001 : 4'b1000;
      #1;
      n_tests++; if (ifb.gnt !== g_exp) begin n_fail++; $display("FAIL rr gnt[%0d] got %b want %b", c, ifb.gnt, g_exp); end
      for (int i = 0; i < REQ; i++) begin
        if (ifb.req[i] && !ifb.gnt[i]) wait_cnt[i]++; else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      exp_cr = exp_cr - 1 + ((c >= 2) ? 1 : 0);
      @(posedge clk); #1;
      n_tests++; if (ifb.wb_wd[0] !== dat(8'hB0, gi)) begin n_fail++; $display("FAIL rr lane0[%0d] got %h", c, ifb.wb_wd[0]); end
      n_tests++; if (ifb.credit !== 5'(exp_cr)) begin n_fail++; $display("FAIL rr credit[%0d] got %0d want %0d", c, ifb.credit, exp_cr); end
      @(negedge clk);
    end
    n_tests++; if (max_wait > REQ) begin n_fail++; $display("FAIL rr max_wait got %0d want <= %0d", max_wait, REQ); end
    ifb.req = '0; ifb.pop = '0;
  endtask

  initial begin
    reset = 1'b0;
    ifa.req = '0; ifa.req_data = '0; ifa.pop = '0; ifa.flush_req = 1'b0;
    ifb.req = '0; ifb.req_data = '0; ifb.pop = '0; ifb.flush_req = 1'b0;
    model_reset();
    obs_gnt = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_pack();
    test_pop_req();
    test_flush();
    test_random();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
